// File: rtl/mdr_pkg.sv
// Shared types for the MDR datapath: opcode encoding, sequencer states and default width.
package mdr_pkg;

  localparam int DEFAULT_WORD_LENGTH = 16;

  typedef enum logic [1:0] {
    MULTIPLIER  = 2'd0,
    DIVISOR     = 2'd1,
    SQUARE_ROOT = 2'd2,
    ILLEGAL     = 2'd3
  } mdr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_X = 3'd1,
    ST_LOAD_Y = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/mdr_operand_sequencer_if.sv
// Request/operand bus between the user side and the MDR operand sequencer.
interface mdr_operand_sequencer_if #(
  parameter int WORD_LENGTH = mdr_pkg::DEFAULT_WORD_LENGTH
);
  logic                   Start;
  logic                   Load;
  logic [1:0]             Opcode_in;
  logic [WORD_LENGTH-1:0] Data_in;
  logic                   Done;

  logic [WORD_LENGTH-1:0] DataX;
  logic [WORD_LENGTH-1:0] DataY;
  logic [1:0]             Opcode;
  logic                   Core_start;
  logic                   Load_x_led;
  logic                   Load_y_led;
  logic                   Ready;
  logic                   Illegal_op;
  logic                   Timeout;

  modport master (
    output Start, Load, Opcode_in, Data_in, Done,
    input  DataX, DataY, Opcode, Core_start, Load_x_led, Load_y_led,
           Ready, Illegal_op, Timeout
  );

  modport slave (
    input  Start, Load, Opcode_in, Data_in, Done,
    output DataX, DataY, Opcode, Core_start, Load_x_led, Load_y_led,
           Ready, Illegal_op, Timeout
  );
endinterface

// File: rtl/mdr_watchdog_counter.sv
// Saturating cycle counter that flags when it has reached LIMIT-1; used to bound the wait on the core.
module mdr_watchdog_counter #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mdr_operand_sequencer.sv
// Operand sequencer: captures opcode and operands from a shared bus, issues a one-cycle core start, waits for done.
module mdr_operand_sequencer
  import mdr_pkg::*;
#(
  parameter int WORD_LENGTH    = DEFAULT_WORD_LENGTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  mdr_operand_sequencer_if.slave  bus
);

  seq_state_e state_q, state_d;
  mdr_op_e    op_in, op_q;

  logic [WORD_LENGTH-1:0] data_x, data_y;
  logic illegal_q, timeout_q;

  logic accept_start, illegal_req, cap_x, cap_y;
  logic wd_clear, wd_en, wd_expired, set_timeout;

  assign op_in = mdr_op_e'(bus.Opcode_in);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    illegal_req  = 1'b0;
    cap_x        = 1'b0;
    cap_y        = 1'b0;
    wd_clear     = 1'b0;
    wd_en        = 1'b0;
    set_timeout  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          if (op_in == ILLEGAL) begin
            illegal_req = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            accept_start = 1'b1;
            state_d      = (op_in == SQUARE_ROOT) ? ST_LOAD_Y : ST_LOAD_X;
          end
        end
      end
      ST_LOAD_X: begin
        if (bus.Load) begin
          cap_x   = 1'b1;
          state_d = ST_LOAD_Y;
        end
      end
      ST_LOAD_Y: begin
        if (bus.Load) begin
          cap_y   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_clear = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        if (bus.Done) begin
          state_d = ST_DONE;
        end else if (wd_expired) begin
          set_timeout = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= MULTIPLIER;
      data_x    <= '0;
      data_y    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (accept_start) op_q <= op_in;
      if (cap_x) data_x <= bus.Data_in;
      if (cap_y) begin
        data_y <= bus.Data_in;
        // Square root has a single operand; X is zeroed so the core sees a clean pair.
        if (op_q == SQUARE_ROOT) data_x <= '0;
      end
      if (illegal_req)       illegal_q <= 1'b1;
      else if (accept_start) illegal_q <= 1'b0;
      if (set_timeout)                      timeout_q <= 1'b0 | 1'b1;
      else if (accept_start || illegal_req) timeout_q <= 1'b0;
    end
  end

  mdr_watchdog_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  assign bus.DataX      = data_x;
  assign bus.DataY      = data_y;
  assign bus.Opcode     = op_q;
  assign bus.Core_start = (state_q == ST_ISSUE);
  assign bus.Load_x_led = (state_q == ST_LOAD_X);
  assign bus.Load_y_led = (state_q == ST_LOAD_Y);
  assign bus.Ready      = (state_q == ST_DONE);
  assign bus.Illegal_op = illegal_q;
  assign bus.Timeout    = timeout_q;

endmodule

// File: tb/tb_mdr_operand_sequencer.sv
// Directed bench for mdr_operand_sequencer: normal, square-root, illegal, watchdog, ignored-strobe and reset flows.
module tb_mdr_operand_sequencer;

  localparam int WL = 16;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   cs_count = 0;
  int   lx_count = 0;
  int   cs_base;
  int   lx_base;

  mdr_operand_sequencer_if #(.WORD_LENGTH(WL)) bus ();

  mdr_operand_sequencer #(
    .WORD_LENGTH    (WL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.Core_start) cs_count++;
    if (bus.Load_x_led) lx_count++;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [1:0] op);
    bus.Start     = 1'b1;
    bus.Opcode_in = op;
    cyc(1);
    bus.Start     = 1'b0;
  endtask

  task automatic do_load(input logic [WL-1:0] d);
    bus.Load    = 1'b1;
    bus.Data_in = d;
    cyc(1);
    bus.Load    = 1'b0;
  endtask

  // Moore flags {Core_start, Load_x_led, Load_y_led, Ready}
  function automatic logic [3:0] flags();
    return {bus.Core_start, bus.Load_x_led, bus.Load_y_led, bus.Ready};
  endfunction

  initial begin
    reset         = 1'b1;
    bus.Start     = 1'b0;
    bus.Load      = 1'b0;
    bus.Opcode_in = 2'd0;
    bus.Data_in   = '0;
    bus.Done      = 1'b0;
    cyc(2);
    reset = 1'b0;

    // Reset state
    check("rst_flags", 32'(flags()), 32'h0);
    check("rst_datax", 32'(bus.DataX), 32'h0);
    check("rst_datay", 32'(bus.DataY), 32'h0);
    check("rst_opcode", 32'(bus.Opcode), 32'h0);
    check("rst_sticky", 32'({bus.Illegal_op, bus.Timeout}), 32'h0);

    // MULTIPLIER flow; Start+Load together: Load must be ignored
    bus.Load    = 1'b1;
    bus.Data_in = 16'hBEEF;
    do_start(2'd0);
    bus.Load = 1'b0;
    check("mul_ldx_led", 32'(flags()), 32'b0100);
    check("start_load_ignored", 32'(bus.DataX), 32'h0);
    do_load(16'h0012);
    check("mul_ldy_led", 32'(flags()), 32'b0010);
    check("mul_datax", 32'(bus.DataX), 32'h0012);
    cs_base = cs_count;
    do_load(16'h0034);
    check("mul_core_start", 32'(flags()), 32'b1000);
    check("mul_datay", 32'(bus.DataY), 32'h0034);
    cyc(1);
    check("mul_wait_flags", 32'(flags()), 32'h0);
    // Start and Load in WAIT are ignored
    bus.Start = 1'b1; bus.Opcode_in = 2'd1;
    bus.Load  = 1'b1; bus.Data_in   = 16'hFFFF;
    cyc(1);
    bus.Start = 1'b0; bus.Load = 1'b0;
    check("wait_ign_flags", 32'(flags()), 32'h0);
    check("wait_ign_data", 32'({bus.DataX, bus.DataY}), 32'h0012_0034);
    check("wait_ign_opcode", 32'(bus.Opcode), 32'h0);
    cyc(2);
    bus.Done = 1'b1;
    cyc(1);
    bus.Done = 1'b0;
    check("mul_ready", 32'(flags()), 32'b0001);
    check("mul_cs_pulses", 32'(cs_count - cs_base), 32'd1);
    check("mul_timeout", 32'(bus.Timeout), 32'h0);
    cyc(2);
    check("done_hold", 32'({bus.DataX, bus.DataY}), 32'h0012_0034);
    check("done_hold_ready", 32'(bus.Ready), 32'h1);

    // SQUARE_ROOT flow from DONE
    lx_base = lx_count;
    cs_base = cs_count;
    do_start(2'd2);
    check("sqrt_ldy_led", 32'(flags()), 32'b0010);
    check("sqrt_opcode", 32'(bus.Opcode), 32'h2);
    do_load(16'h0051);
    check("sqrt_core_start", 32'(flags()), 32'b1000);
    check("sqrt_datay", 32'(bus.DataY), 32'h0051);
    check("sqrt_datax_zero", 32'(bus.DataX), 32'h0);
    cyc(2);
    bus.Done = 1'b1;
    cyc(1);
    bus.Done = 1'b0;
    check("sqrt_ready", 32'(bus.Ready), 32'h1);
    check("sqrt_cs_pulses", 32'(cs_count - cs_base), 32'd1);
    check("sqrt_no_ldx", 32'(lx_count - lx_base), 32'd0);

    // Illegal opcode from DONE
    do_start(2'd3);
    check("ill_flag", 32'(bus.Illegal_op), 32'h1);
    check("ill_idle", 32'(flags()), 32'h0);
    check("ill_opcode_kept", 32'(bus.Opcode), 32'h2);
    do_start(2'd1);
    check("ill_cleared", 32'(bus.Illegal_op), 32'h0);
    check("div_ldx_led", 32'(flags()), 32'b0100);
    check("div_opcode", 32'(bus.Opcode), 32'h1);
    // Done in LOAD_X is ignored
    bus.Done = 1'b1;
    cyc(1);
    bus.Done = 1'b0;
    check("ldx_done_ign", 32'(flags()), 32'b0100);
    check("ldx_done_data", 32'(bus.DataX), 32'h0);

    // Watchdog: Done withheld
    do_load(16'h00A0);
    do_load(16'h0005);
    check("div_core_start", 32'(flags()), 32'b1000);
    cyc(TO);
    check("wd_last_wait", 32'({bus.Timeout, flags()}), 32'h0);
    cyc(1);
    check("wd_timeout", 32'(bus.Timeout), 32'h1);
    check("wd_idle", 32'(flags()), 32'h0);
    check("wd_data_kept", 32'({bus.DataX, bus.DataY}), 32'h00A0_0005);

    // Done on the final WAIT cycle wins over expiry
    do_start(2'd0);
    check("to_cleared", 32'(bus.Timeout), 32'h0);
    do_load(16'h0007);
    do_load(16'h0009);
    cyc(TO);
    bus.Done = 1'b1;
    cyc(1);
    bus.Done = 1'b0;
    check("wd_done_wins", 32'(bus.Ready), 32'h1);
    check("wd_done_no_to", 32'(bus.Timeout), 32'h0);

    // Reset in WAIT
    do_start(2'd1);
    do_load(16'h1111);
    do_load(16'h2222);
    cyc(3);
    cs_base = cs_count;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("midrst_flags", 32'(flags()), 32'h0);
    check("midrst_data", 32'({bus.DataX, bus.DataY}), 32'h0);
    check("midrst_opcode", 32'(bus.Opcode), 32'h0);
    cyc(3);
    check("midrst_no_cs", 32'(cs_count - cs_base), 32'd0);
    check("midrst_idle", 32'(flags()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
